// File: rtl/bit_deserializer.sv
// Serial deserializer: hunts for SYNC_WORD on the synchronized line, then emits FRAME_LEN bytes; no backpressure.
// data_valid follows a clk_rec pin edge by ~4 clk_200M cycles. DESER_AUTO_POLARITY_EN also locks on an inverted sync byte.
module bit_deserializer #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic        clk_200M,
    input  logic        rst,
    input  logic        signal,
    input  logic        clk_rec,
    input  logic [15:0] clk_freq,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        err_timeout,
    output logic        polarity_inv
);

    typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

    logic        sig_s1, sig_s2;
    logic        rec_s1, rec_s2, rec_s3;
    state_t      state, state_nxt;
    logic [7:0]  sr, sr_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  byte_cnt, byte_cnt_nxt;
    logic [16:0] gap, gap_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt, start_nxt, done_nxt, timeout_nxt;
    logic        bit_evt, line_bit, timeout_hit;
    logic [7:0]  sr_shift;

    // clk_rec is sampled as data, so both inputs share the same synchronizer depth.
    always_ff @(posedge clk_200M) begin
        if (rst) begin
            sig_s1 <= 1'b0;
            sig_s2 <= 1'b0;
            rec_s1 <= 1'b0;
            rec_s2 <= 1'b0;
            rec_s3 <= 1'b0;
        end else begin
            sig_s1 <= signal;
            sig_s2 <= sig_s1;
            rec_s1 <= clk_rec;
            rec_s2 <= rec_s1;
            rec_s3 <= rec_s2;
        end
    end

    assign bit_evt = rec_s2 & ~rec_s3;

`ifdef DESER_AUTO_POLARITY_EN
    logic pol_q, pol_nxt;

    assign line_bit     = sig_s2 ^ pol_q;
    assign polarity_inv = pol_q;

    always_ff @(posedge clk_200M) begin
        if (rst) pol_q <= 1'b0;
        else     pol_q <= pol_nxt;
    end
`else
    assign line_bit     = sig_s2;
    assign polarity_inv = 1'b0;
`endif

    assign sr_shift    = {sr[6:0], line_bit};
    assign gap_nxt     = bit_evt ? 17'd0 : ((&gap) ? gap : gap + 17'd1);
    assign timeout_hit = (clk_freq != 16'd0) && ({1'b0, gap} >= {clk_freq, 2'b00});
    assign locked      = (state == DATA);

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        data_nxt     = data_out;
        valid_nxt    = 1'b0;
        start_nxt    = 1'b0;
        done_nxt     = 1'b0;
        timeout_nxt  = 1'b0;
`ifdef DESER_AUTO_POLARITY_EN
        pol_nxt      = pol_q;
`endif
        if (bit_evt) sr_nxt = sr_shift;

        case (state)
            HUNT: begin
                if (bit_evt && sr_shift == SYNC_WORD) begin
                    state_nxt    = DATA;
                    bit_cnt_nxt  = 3'd0;
                    byte_cnt_nxt = 8'd0;
`ifdef DESER_AUTO_POLARITY_EN
                    pol_nxt      = 1'b0;
                end else if (bit_evt && sr_shift == ~SYNC_WORD) begin
                    state_nxt    = DATA;
                    bit_cnt_nxt  = 3'd0;
                    byte_cnt_nxt = 8'd0;
                    pol_nxt      = 1'b1;
`endif
                end
            end
            DATA: begin
                if (bit_evt) begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = 3'd0;
                        data_nxt    = sr_shift;
                        valid_nxt   = 1'b1;
                        start_nxt   = (byte_cnt == 8'd0);
                        if (byte_cnt == LAST_BYTE) begin
                            done_nxt     = 1'b1;
                            state_nxt    = HUNT;
                            byte_cnt_nxt = 8'd0;
                        end else begin
                            byte_cnt_nxt = byte_cnt + 8'd1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else if (timeout_hit) begin
                    // Lost bit clock: the partial byte is dropped, sr keeps its history.
                    state_nxt    = HUNT;
                    timeout_nxt  = 1'b1;
                    bit_cnt_nxt  = 3'd0;
                    byte_cnt_nxt = 8'd0;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            state       <= HUNT;
            sr          <= 8'd0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 8'd0;
            gap         <= 17'd0;
            data_out    <= 8'd0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            byte_cnt    <= byte_cnt_nxt;
            gap         <= gap_nxt;
            data_out    <= data_nxt;
            data_valid  <= valid_nxt;
            frame_start <= start_nxt;
            frame_done  <= done_nxt;
            err_timeout <= timeout_nxt;
        end
    end

endmodule
